// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - N-bit universal shift/rotate/load register with shift counter
//
// Purpose: N-bit register that can hold, shift or rotate STEP bits per enabled
// clock in either direction, parallel load, or clear. A shift counter marks each
// complete word transit with a one-cycle registered done pulse.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-high reset
//   en               operation enable (low = hold)
//   mode[2:0]        000 hold, 001 shr, 010 shl, 011 rotr, 100 rotl,
//                    101 load, 110 clear, 111 hold
//   serial_in_left   STEP bits entering the MSB end on shift right
//   serial_in_right  STEP bits entering the LSB end on shift left
//   parallel_in      load data
//   parallel_out     register contents
//   serial_out_left  top STEP bits of the register
//   serial_out_right bottom STEP bits of the register
//   shift_count      shift/rotate operations since load/clear, modulo N/STEP
//   done             one-cycle pulse after the N/STEP-th shift/rotate
module universal_shift_reg #(
  parameter int N    = 8,
  parameter int STEP = 1,
  localparam int CW  = ((N / STEP) > 2) ? $clog2(N / STEP) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      mode,
  input  logic [STEP-1:0] serial_in_left,
  input  logic [STEP-1:0] serial_in_right,
  input  logic [N-1:0]    parallel_in,
  output logic [N-1:0]    parallel_out,
  output logic [STEP-1:0] serial_out_left,
  output logic [STEP-1:0] serial_out_right,
  output logic [CW-1:0]   shift_count,
  output logic            done
);

  if (N < 2 || STEP < 1 || STEP > N / 2 || (N % STEP) != 0) begin : g_bad_params
    $error("universal_shift_reg: illegal N/STEP combination");
  end

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROTR  = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  // Final count value of a word transit; reaching it wraps the counter.
  localparam logic [CW-1:0] LAST_COUNT = CW'(N / STEP - 1);

  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          advance;

  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    done_d  = 1'b0;
    advance = 1'b0;

    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHR: begin
          q_d     = {serial_in_left, q_q[N-1:STEP]};
          advance = 1'b1;
        end
        MODE_SHL: begin
          q_d     = {q_q[N-1-STEP:0], serial_in_right};
          advance = 1'b1;
        end
        MODE_ROTR: begin
          q_d     = {q_q[STEP-1:0], q_q[N-1:STEP]};
          advance = 1'b1;
        end
        MODE_ROTL: begin
          q_d     = {q_q[N-1-STEP:0], q_q[N-1 -: STEP]};
          advance = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = parallel_in;
          count_d = '0;
        end
        MODE_CLEAR: begin
          q_d     = '0;
          count_d = '0;
        end
        default: ;  // reserved encoding behaves as hold
      endcase
    end

    // Counting is per operation, independent of direction.
    if (advance) begin
      if (count_q == LAST_COUNT) begin
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q     <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign parallel_out     = q_q;
  assign serial_out_left  = q_q[N-1 -: STEP];
  assign serial_out_right = q_q[STEP-1:0];
  assign shift_count      = count_q;
  assign done             = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // N=8, STEP=1 instance
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       sil = 1'b0, sir = 1'b0;
  logic [7:0] pin = 8'h00;
  logic [7:0] pout;
  logic       sol, sor;
  logic [2:0] cnt;
  logic       done;

  // N=8, STEP=2 instance
  logic       en2 = 1'b0;
  logic [2:0] mode2 = 3'b000;
  logic [1:0] sil2 = 2'b00, sir2 = 2'b00;
  logic [7:0] pin2 = 8'h00;
  logic [7:0] pout2;
  logic [1:0] sol2, sor2;
  logic [1:0] cnt2;
  logic       done2;

  universal_shift_reg #(.N(8), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .serial_in_left(sil), .serial_in_right(sir), .parallel_in(pin),
    .parallel_out(pout), .serial_out_left(sol), .serial_out_right(sor),
    .shift_count(cnt), .done(done)
  );

  universal_shift_reg #(.N(8), .STEP(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .mode(mode2),
    .serial_in_left(sil2), .serial_in_right(sir2), .parallel_in(pin2),
    .parallel_out(pout2), .serial_out_left(sol2), .serial_out_right(sor2),
    .shift_count(cnt2), .done(done2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic op(input logic e, input logic [2:0] m);
    en = e;
    mode = m;
    tick();
  endtask

  task automatic op2(input logic e, input logic [2:0] m);
    en2 = e;
    mode2 = m;
    tick();
  endtask

  logic [7:0] seq;
  logic [7:0] exp2 [4];

  initial begin
    // reset state
    tick();
    chk("rst_q", pout, 8'h00);
    chk("rst_cnt", cnt, 3'd0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;

    // build q=A5, count=3: 2D rotated right three times
    pin = 8'h2D;
    op(1'b1, 3'b101);
    chk("pre_load", pout, 8'h2D);
    repeat (3) op(1'b1, 3'b011);
    chk("pre_q", pout, 8'hA5);
    chk("pre_cnt", cnt, 3'd3);

    // asynchronous reset mid-cycle, enable still active
    #2 reset = 1'b1;
    #1;
    chk("async_q", pout, 8'h00);
    chk("async_cnt", cnt, 3'd0);
    chk("async_done", done, 1'b0);
    tick();
    chk("held_q", pout, 8'h00);
    chk("held_cnt", cnt, 3'd0);
    reset = 1'b0;

    // SISO: shift in 1,0,1,1,0,0,1,0 (bits 0..7 of 4D)
    seq = 8'h4D;
    pin = 8'h00;
    op(1'b1, 3'b101);
    chk("siso_load", pout, 8'h00);
    for (int k = 0; k < 8; k++) begin
      sil = seq[k];
      op(1'b1, 3'b001);
      chk("siso_done", done, (k == 7) ? 1'b1 : 1'b0);
      chk("siso_cnt", cnt, 32'((k + 1) % 8));
    end
    chk("siso_q", pout, 8'h4D);
    chk("siso_sol", sol, 1'b0);
    chk("siso_sor", sor, 1'b1);
    op(1'b1, 3'b000);
    chk("siso_hold_q", pout, 8'h4D);
    chk("siso_hold_done", done, 1'b0);
    // serial_out_right replays the word LSB first
    sil = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("siso_replay", sor, seq[k]);
      op(1'b1, 3'b001);
    end
    chk("replay_q", pout, 8'h00);
    chk("replay_done", done, 1'b1);
    chk("replay_cnt", cnt, 3'd0);

    // rotate left 8 times from B4
    pin = 8'hB4;
    op(1'b1, 3'b101);
    chk("rot_load_done", done, 1'b0);
    chk("rot_load_cnt", cnt, 3'd0);
    op(1'b1, 3'b100);
    chk("rotl1", pout, 8'h69);
    repeat (6) op(1'b1, 3'b100);
    chk("rotl7_done", done, 1'b0);
    chk("rotl7_cnt", cnt, 3'd7);
    op(1'b1, 3'b100);
    chk("rotl8_q", pout, 8'hB4);
    chk("rotl8_done", done, 1'b1);
    chk("rotl8_cnt", cnt, 3'd0);
    op(1'b0, 3'b100);
    chk("en0_done", done, 1'b0);
    chk("en0_q", pout, 8'hB4);
    op(1'b1, 3'b011);
    chk("rotr1", pout, 8'h5A);
    chk("rotr1_cnt", cnt, 3'd1);

    // shift left with enable gaps
    pin = 8'h81;
    op(1'b1, 3'b101);
    sir = 1'b1;
    op(1'b1, 3'b010);
    chk("shl_e1", pout, 8'h03);
    op(1'b0, 3'b010);
    chk("shl_gap1", pout, 8'h03);
    op(1'b1, 3'b010);
    chk("shl_e2", pout, 8'h07);
    op(1'b0, 3'b010);
    chk("shl_gap2", pout, 8'h07);
    op(1'b1, 3'b010);
    chk("shl_q", pout, 8'h0F);
    chk("shl_cnt", cnt, 3'd3);
    chk("shl_done", done, 1'b0);

    // load / reserved / clear mid-sequence
    op(1'b1, 3'b010);
    op(1'b1, 3'b010);
    chk("mid_q", pout, 8'h3F);
    chk("mid_cnt", cnt, 3'd5);
    pin = 8'h3C;
    op(1'b1, 3'b101);
    chk("mid_load_q", pout, 8'h3C);
    chk("mid_load_cnt", cnt, 3'd0);
    pin = 8'hFF;
    op(1'b1, 3'b111);
    chk("rsvd_q", pout, 8'h3C);
    chk("rsvd_cnt", cnt, 3'd0);
    op(1'b0, 3'b110);
    chk("clr_en0_q", pout, 8'h3C);
    op(1'b1, 3'b110);
    chk("clr_q", pout, 8'h00);
    chk("clr_cnt", cnt, 3'd0);

    // mixed directions keep counting
    op(1'b1, 3'b100);
    sir = 1'b1;
    op(1'b1, 3'b010);
    chk("mix_shl", pout, 8'h01);
    sil = 1'b1;
    op(1'b1, 3'b001);
    chk("mix_shr", pout, 8'h80);
    op(1'b1, 3'b011);
    chk("mix_rotr", pout, 8'h40);
    chk("mix_cnt", cnt, 3'd4);
    en = 1'b0;

    // STEP=2: E4 shifted right with 01 entering four times
    exp2[0] = 8'h79;
    exp2[1] = 8'h5E;
    exp2[2] = 8'h57;
    exp2[3] = 8'h55;
    pin2 = 8'hE4;
    op2(1'b1, 3'b101);
    chk("s2_load", pout2, 8'hE4);
    sil2 = 2'b01;
    for (int k = 0; k < 4; k++) begin
      op2(1'b1, 3'b001);
      chk("s2_q", pout2, exp2[k]);
      chk("s2_done", done2, (k == 3) ? 1'b1 : 1'b0);
      chk("s2_cnt", cnt2, 32'((k + 1) % 4));
    end
    chk("s2_sol", sol2, 2'b01);
    chk("s2_sor", sor2, 2'b01);
    op2(1'b1, 3'b000);
    chk("s2_hold_done", done2, 1'b0);
    chk("s2_hold_q", pout2, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
